// File: rtl/instruction_register_pkg.sv
// Shared processor definitions: instruction word width, fixed field
// positions inside the instruction word, and the opcode encoding used
// by the control unit.
package instruction_register_pkg;

    localparam int WIDTH      = 16;
    localparam int OPCODE_W   = 5;
    localparam int REG_W      = 3;
    localparam int OPCODE_MSB = 15;
    localparam int REG_X_LSB  = 8;
    localparam int REG_Y_LSB  = 5;
    localparam int IMM_W      = 8;

    // Opcode encoding as seen by the control unit (top five bits of the word).
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 5'h00,
        OP_ADD  = 5'h01,
        OP_SUB  = 5'h02,
        OP_AND  = 5'h03,
        OP_OR   = 5'h04,
        OP_XOR  = 5'h05,
        OP_LDI  = 5'h08,
        OP_LD   = 5'h09,
        OP_ST   = 5'h0A,
        OP_BEQ  = 5'h10,
        OP_BNE  = 5'h11,
        OP_JMP  = 5'h12,
        OP_HALT = 5'h1F
    } opcode_e;

    // Opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [WIDTH-1:0] word);
        return word[OPCODE_MSB -: OPCODE_W];
    endfunction

endpackage

// File: rtl/instruction_register.sv
// Instruction register: captures the fetched instruction word on ir_load and
// presents it, with fixed-position decoded fields, until the next load.
// All outputs come from the stored word only; in_value never reaches an
// output combinationally.
module instruction_register
    import instruction_register_pkg::*;
#(
    parameter int WIDTH    = instruction_register_pkg::WIDTH,
    parameter int OPCODE_W = instruction_register_pkg::OPCODE_W,
    parameter int REG_W    = instruction_register_pkg::REG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ir_load,
    input  logic [WIDTH-1:0]    in_value,
    output logic [WIDTH-1:0]    out_value,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    reg_x,
    output logic [REG_W-1:0]    reg_y,
    output logic [IMM_W-1:0]    imm,
    output logic                valid
);

    logic [WIDTH-1:0] r_value;
    logic             r_valid;

    // Storage register: async clear, load on ir_load, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_valid <= 1'b0;
        end else if (ir_load) begin
            r_value <= in_value;
            r_valid <= 1'b1;
        end
    end

    assign out_value = r_value;
    assign valid     = r_valid;

    // Decoded fields are plain slices of the held word; reg_y and imm overlap
    // on purpose and the control unit picks one based on the opcode.
    assign opcode = r_value[OPCODE_MSB -: OPCODE_W];
    assign reg_x  = r_value[REG_X_LSB +: REG_W];
    assign reg_y  = r_value[REG_Y_LSB +: REG_W];
    assign imm    = r_value[IMM_W-1:0];

endmodule

// File: tb/tb_instruction_register.sv
// Directed testbench for instruction_register: a table of clocked load/hold
// vectors plus hand-written sequences for asynchronous reset behaviour.
module tb_instruction_register;

    logic        clk;
    logic        reset;
    logic        ir_load;
    logic [15:0] in_value;
    logic [15:0] out_value;
    logic [4:0]  opcode;
    logic [2:0]  reg_x;
    logic [2:0]  reg_y;
    logic [7:0]  imm;
    logic        valid;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        load;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[12];

    instruction_register dut (
        .clk       (clk),
        .reset     (reset),
        .ir_load   (ir_load),
        .in_value  (in_value),
        .out_value (out_value),
        .opcode    (opcode),
        .reg_x     (reg_x),
        .reg_y     (reg_y),
        .imm       (imm),
        .valid     (valid)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Check the full output set against an expected word and valid flag;
    // field expectations are the architectural bit positions of that word.
    task automatic chk_all(input string name, input logic [15:0] w, input logic v);
        chk({name, ".out"},    out_value,        w);
        chk({name, ".valid"},  {15'd0, valid},   {15'd0, v});
        chk({name, ".opcode"}, {11'd0, opcode},  {11'd0, w[15:11]});
        chk({name, ".reg_x"},  {13'd0, reg_x},   {13'd0, w[10:8]});
        chk({name, ".reg_y"},  {13'd0, reg_y},   {13'd0, w[7:5]});
        chk({name, ".imm"},    {8'd0, imm},      {8'd0, w[7:0]});
    endtask

    // Drive inputs on the falling edge, sample 1 unit after the rising edge.
    task automatic step(input logic ld, input logic [15:0] d);
        @(negedge clk);
        ir_load  = ld;
        in_value = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 16'hAAAA, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'hFDFD, 16'hFDFD, 1'b1};
        vecs[2]  = '{1'b0, 16'hBABA, 16'hFDFD, 1'b1};
        vecs[3]  = '{1'b0, 16'h1234, 16'hFDFD, 1'b1};
        vecs[4]  = '{1'b1, 16'h1111, 16'h1111, 1'b1};
        vecs[5]  = '{1'b1, 16'h2222, 16'h2222, 1'b1};
        vecs[6]  = '{1'b1, 16'h3333, 16'h3333, 1'b1};
        vecs[7]  = '{1'b0, 16'hBABA, 16'h3333, 1'b1};
        vecs[8]  = '{1'b1, 16'hBABA, 16'hBABA, 1'b1};
        vecs[9]  = '{1'b0, 16'h5555, 16'hBABA, 1'b1};
        vecs[10] = '{1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{1'b1, 16'hBABA, 16'hBABA, 1'b1};

        // Reset asserted with load active and arbitrary data, before any edge.
        reset    = 1'b1;
        ir_load  = 1'b1;
        in_value = 16'($urandom);
        #1;
        chk_all("reset_noclk", 16'h0000, 1'b0);

        @(negedge clk);
        reset   = 1'b0;
        ir_load = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].load, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
            if (i == 1) begin
                chk("fdfd.opcode", {11'd0, opcode}, 16'h001F);
                chk("fdfd.reg_x",  {13'd0, reg_x},  16'h0005);
                chk("fdfd.reg_y",  {13'd0, reg_y},  16'h0007);
                chk("fdfd.imm",    {8'd0, imm},     16'h00FD);
            end
        end

        // Input changes between edges with load low must not reach outputs.
        @(negedge clk);
        ir_load  = 1'b0;
        in_value = 16'h7E7E;
        #2;
        in_value = 16'hC3C3;
        #1;
        chk_all("no_comb_path", 16'hBABA, 1'b1);

        // Async reset pulsed between edges clears immediately.
        reset = 1'b1;
        #1;
        chk_all("async_reset", 16'h0000, 1'b0);

        // Reset has priority over a load across a rising edge.
        ir_load  = 1'b1;
        in_value = 16'hFFFF;
        @(posedge clk);
        #1;
        chk_all("reset_priority", 16'h0000, 1'b0);

        // First edge after release with load high captures normally.
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 16'h0F0F);
        chk_all("load_after_reset", 16'h0F0F, 1'b1);
        step(1'b0, 16'h9999);
        chk_all("hold_after_reset", 16'h0F0F, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_register.md
Name: instruction_register

Overview:
- Holds the instruction currently being executed by the processor datapath.
- Captures the 16-bit word fetched from instruction memory when the control unit asserts ir_load.
- Presents the captured word, plus fixed-position decoded fields, to the control unit and register file until the next load.
- Sits between the instruction-memory read port and the decode/control logic.

Parameters:
- WIDTH, 16, instruction word width in bits.
- OPCODE_W, 5, width of the opcode field taken from the MSBs.
- REG_W, 3, width of each register-select field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ir_load  input  1  load enable; captures in_value at the next rising clk edge.
- in_value  input  WIDTH  instruction word from instruction memory.
- out_value  output  WIDTH  currently held instruction word.
- opcode  output  OPCODE_W  out_value[15:11].
- reg_x  output  REG_W  out_value[10:8].
- reg_y  output  REG_W  out_value[7:5].
- imm  output  8  out_value[7:0].
- valid  output  1  1 once at least one load has completed since reset.

Behaviour:
- Single WIDTH-bit storage register; out_value is driven directly by the register, with no combinational path from in_value.
- Reset:
  - While reset is 1, the register clears to 0 and valid clears to 0 immediately, independent of clk.
  - All decoded fields therefore read 0 during and after reset.
  - Reset has priority over ir_load.
- Load:
  - On a rising clk edge with reset=0 and ir_load=1, register <= in_value and valid <= 1.
  - Latency is one edge: the new value is visible on out_value after that edge.
- Hold:
  - On a rising edge with ir_load=0, the register and valid keep their values.
  - Changes on in_value while ir_load=0 never affect outputs, including changes made in the same cycle that ir_load deasserts.
- Back-to-back loads: ir_load held high for N edges captures in_value at each edge; the last capture wins.
- Reset released mid-sequence: the first rising edge after release with ir_load=1 loads normally.
- Decoded fields:
  - Pure combinational slices of the stored register, never of in_value.
  - They change only when out_value changes.
  - reg_y and imm overlap by design; the control unit chooses which to use per opcode.
- ir_load sampled as X/Z is illegal; no requirement on the result.

Decomposition:
- Shared processor package holds WIDTH (16), the field bit-position constants (OPCODE_MSB=15, REG_X_LSB=8, REG_Y_LSB=5, IMM_W=8), and an opcode enum type used by the control unit.
- No sub-module needed; a single flat module with one always block for the register and continuous assigns for the fields.

Test Plan:
- Reset: assert reset with random in_value and ir_load=1 -> out_value=16'h0000, valid=0, opcode=0, all fields 0, without any clock edge.
- Basic load: in_value=16'hFDFD, ir_load=1, one rising edge, then ir_load=0 and another edge -> out_value=16'hFDFD, opcode=5'h1F, reg_x=3'h5, reg_y=3'h7, imm=8'hFD, valid=1.
- Hold against input change: load 16'hFDFD, deassert ir_load, set in_value=16'hBABA, clock one edge -> out_value stays 16'hFDFD.
- Back-to-back: ir_load=1 across three edges with in_value 16'h1111, 16'h2222, 16'h3333 -> out_value is 16'h1111, 16'h2222, 16'h3333 after each respective edge.
- Async reset mid-hold: after holding 16'hBABA, pulse reset between edges -> out_value=16'h0000 immediately; next load of 16'h0F0F -> out_value=16'h0F0F, valid=1.
- Reset priority: reset=1 and ir_load=1 with in_value=16'hFFFF across an edge -> out_value remains 16'h0000.
